// File: rtl/if_icache_fetch.sv
// Instruction-fetch stage with a direct-mapped, one-word-per-line I-cache.
// A hit delivers pc/instruction to decode the next cycle, sustaining one
// instruction per cycle. A miss requests one word over the shared RAM port
// (busy/read/ready), fills the line, and then retries the lookup. A redirect
// from execute flushes the output slot. A refill that is already in flight
// still completes into the cache.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   br, br_addr        redirect pulse and target (bits [1:0] ignored)
//   out_ready          decode accepts the output slot this cycle
//   out_valid, pc_o, inst_o  output slot to decode
//   stall_if           high whenever a miss is being serviced
//   ram_busy           RAM port owned by another requester
//   ram_read, ram_addr read request (held until ram_ready), word address
//   ram_ready, ram_data single-cycle read-data strobe and data
//   hit_cnt, miss_cnt  saturating hit/miss performance counters
module if_icache_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                LINES    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              stall_if,
  input  logic              ram_busy,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_ready,
  input  logic [INST_W-1:0] ram_data,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX - 2;

  typedef enum logic [1:0] {FETCH, REQ, WAIT} state_t;
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [INST_W-1:0] data;
  } line_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] pc, miss_addr, br_tgt;
  logic [LINES-1:0]  line_vld;
  line_t             lines [LINES];
  logic [IDX-1:0]    idx, fill_idx;
  logic              hit, slot_free;
  logic              do_hit, do_miss, do_issue, do_fill;
  logic              unused_br_lsb;

  // Redirect targets are word aligned; the low bits are don't-care.
  assign br_tgt        = {br_addr[ADDR_W-1:2], 2'b00};
  assign unused_br_lsb = ^br_addr[1:0];

  assign idx       = pc[IDX+1:2];
  assign fill_idx  = miss_addr[IDX+1:2];
  assign hit       = line_vld[idx] && (lines[idx].tag == pc[ADDR_W-1:IDX+2]);
  assign slot_free = !out_valid || out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (!br && !hit && slot_free) state_nxt = REQ;
      REQ:     if (br) state_nxt = FETCH;
               else if (!ram_busy) state_nxt = WAIT;
      WAIT:    if (ram_ready) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Outputs / datapath enables. A redirect suppresses the lookup in FETCH
  // and the request in REQ. It never blocks a fill, so a line that is
  // already on its way is still written.
  always_comb begin
    stall_if = (state != FETCH);
    do_hit   = (state == FETCH) && !br && hit && slot_free;
    do_miss  = (state == FETCH) && !br && !hit && slot_free;
    do_issue = (state == REQ) && !br && !ram_busy;
    do_fill  = (state == WAIT) && ram_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      pc_o      <= '0;
      inst_o    <= '0;
      ram_read  <= 1'b0;
      ram_addr  <= '0;
      miss_addr <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      line_vld  <= '0;
    end else begin
      // Output slot: flushed by redirect, reloaded on hit, drained on a miss
      // that decode has just consumed; otherwise it holds.
      if (br) begin
        pc        <= br_tgt;
        out_valid <= 1'b0;
      end else if (do_hit) begin
        pc_o      <= pc;
        inst_o    <= lines[idx].data;
        out_valid <= 1'b1;
        pc        <= pc + ADDR_W'(4);
      end else if (do_miss && out_ready) begin
        out_valid <= 1'b0;
      end

      if (do_hit && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);

      if (do_miss) begin
        miss_addr <= pc;
        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      end

      if (do_issue) begin
        ram_read <= 1'b1;
        ram_addr <= miss_addr;
      end

      if (do_fill) begin
        ram_read           <= 1'b0;
        line_vld[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage carries no reset; line_vld qualifies every read.
  always_ff @(posedge clk) begin
    if (!reset && do_fill) begin
      lines[fill_idx].tag  <= miss_addr[ADDR_W-1:IDX+2];
      lines[fill_idx].data <= ram_data;
    end
  end
endmodule

// File: tb/tb_if_icache_fetch.sv
module tb_if_icache_fetch;
  localparam int LINES = 64;
  localparam int CNT_W = 6;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk, reset, br, out_ready, out_valid, stall_if;
  logic ram_busy, ram_read, ram_ready;
  logic [31:0] br_addr, pc_o, inst_o, ram_addr, ram_data;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  if_icache_fetch #(
    .ADDR_W(32), .INST_W(32), .LINES(LINES), .RESET_PC(32'h0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .br(br), .br_addr(br_addr),
    .out_ready(out_ready), .out_valid(out_valid), .pc_o(pc_o), .inst_o(inst_o),
    .stall_if(stall_if), .ram_busy(ram_busy), .ram_read(ram_read),
    .ram_addr(ram_addr), .ram_ready(ram_ready), .ram_data(ram_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_err = 0, n_req = 0;
  // Reference model: which word address currently lives in each line,
  // plus expected hit/miss/request totals.
  logic [31:0] line_of [int];
  int m_hit = 0, m_miss = 0, m_req = 0;
  bit rand_busy = 0, force_busy = 0, rand_lat = 0, expect_abort = 0;
  int cur_lat = 3;

  initial begin clk = 0; forever #5 clk = ~clk; end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a < 32'd16) return ({30'd0, a[3:2]} + 32'd1) * 32'h11;
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  // Fetch of word a: a miss allocates the line; deliver means it reached the slot.
  function automatic void model_fetch(input logic [31:0] a, input bit deliver);
    int i = int'((a >> 2) % LINES);
    if (!(line_of.exists(i) && line_of[i] == a)) begin
      m_miss++; m_req++; line_of[i] = a;
    end
    if (deliver) m_hit++;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Busy source; updates at +2 so directed code writing force_busy at +1 wins.
  initial begin
    ram_busy = 0;
    forever begin
      @(posedge clk); #2;
      ram_busy = force_busy || (rand_busy && ($urandom_range(0, 3) == 0));
    end
  end

  // RAM responder. A request that disappears before data is only legal
  // around a reset; that case also fires a stray ram_ready the DUT must ignore.
  initial begin
    logic [31:0] a;
    int lat;
    bit ab;
    ram_ready = 0; ram_data = 0;
    forever begin
      @(negedge clk);
      if (ram_read) begin
        a = ram_addr;
        lat = rand_lat ? int'($urandom_range(1, 5)) : cur_lat;
        ab = 0;
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          if (!ram_read) begin ab = 1; break; end
          check("ram_addr_stable", ram_addr, a);
        end
        if (ab) begin
          check("ram_read_dropped_early", expect_abort, 1);
          ram_ready = 1; ram_data = 32'hDEAD_BEEF;
          @(negedge clk);
          ram_ready = 0;
        end else begin
          ram_ready = 1; ram_data = mem(a);
          @(negedge clk);
          ram_ready = 0;
          check("ram_read_released", ram_read, 0);
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit hold_v;
    logic [31:0] hold_pc, hold_inst;
    logic prev_rd, prev_busy;
    exp_t e;
    hold_v = 0; prev_rd = 0; prev_busy = 0; hold_pc = 0; hold_inst = 0;
    forever begin
      @(negedge clk);
      if (hold_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_pc", pc_o, hold_pc);
        check("hold_inst", inst_o, hold_inst);
      end
      hold_v = out_valid && !out_ready && !br && !reset;
      hold_pc = pc_o; hold_inst = inst_o;
      if (ram_read && !prev_rd) begin
        n_req++;
        check("read_while_busy", prev_busy, 0);
      end
      prev_rd = ram_read; prev_busy = ram_busy;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_output: pc_o=%0h inst_o=%0h with nothing expected", pc_o, inst_o);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", pc_o, e.pc);
          check("out_inst", inst_o, e.inst);
        end
      end
    end
  end

  task automatic check_counts(input string tag);
    check({tag, "_hit_cnt"}, hit_cnt, sat(m_hit));
    check({tag, "_miss_cnt"}, miss_cnt, sat(m_miss));
    check({tag, "_ram_reqs"}, n_req, m_req);
  endtask

  // Fetch run from t accepting n instructions, then leave the DUT holding
  // the next instruction in its slot (out_ready=0) so counts are settled.
  task automatic run(input logic [31:0] t, input int n, input bit do_br,
                     input int pct, input bit stream);
    exp_t e;
    int acc = 0, cyc = 0, first = -1, last = -1;
    for (int i = 0; i < n; i++) begin
      e.pc = t + 32'(4 * i); e.inst = mem(e.pc); exp_q.push_back(e);
    end
    for (int i = 0; i <= n; i++) model_fetch(t + 32'(4 * i), 1);
    if (do_br) begin
      br = 1; br_addr = t | 32'($urandom_range(0, 3));
      @(posedge clk); #1;
      br = 0;
    end
    forever begin
      if (acc == n) begin
        out_ready = 0;
        if (out_valid && !stall_if) break;
      end else begin
        out_ready = (int'($urandom_range(1, 100)) <= pct);
        if (out_valid && out_ready) begin
          if (first < 0) first = cyc;
          last = cyc; acc++;
        end
      end
      if (cyc > 400) begin
        n_cmp++; n_err++;
        $display("FAIL run_timeout: run at %0h accepted %0d of %0d", t, acc, n);
        break;
      end
      @(posedge clk); #1; cyc++;
    end
    if (stream) check("stream_span", last - first, n - 1);
    check_counts("run");
  endtask

  task automatic wait_rd(input string name);
    int k = 0;
    while (!ram_read && k < 100) begin @(posedge clk); #1; k++; end
    check({name, "_rd_seen"}, ram_read, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_pc_o"}, pc_o, 0);
    check({tag, "_inst_o"}, inst_o, 0);
    check({tag, "_ram_read"}, ram_read, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_hit_cnt"}, hit_cnt, 0);
    check({tag, "_miss_cnt"}, miss_cnt, 0);
    check({tag, "_stall_if"}, stall_if, 0);
  endtask

  initial begin
    reset = 1; br = 0; br_addr = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 0;

    // Cold start, then a warm loop over the same words
    run(32'h0, 4, 0, 100, 0);
    run(32'h0, 4, 1, 100, 1);
    // Backpressure
    run(32'h0, 8, 1, 30, 0);

    // Redirect while the 0x100 refill is outstanding
    model_fetch(32'h100, 0);
    br = 1; br_addr = 32'h100; @(posedge clk); #1; br = 0;
    wait_rd("redir");
    br = 1; br_addr = 32'h43; @(posedge clk); #1; br = 0;
    run(32'h40, 3, 0, 100, 0);
    run(32'h100, 1, 1, 100, 0);
    // Aliasing on index 0
    run(32'h0, 1, 1, 100, 0);
    run(32'h100, 1, 1, 100, 0);

    // RAM port busy while a request is pending
    force_busy = 1;
    br = 1; br_addr = 32'h2000; @(posedge clk); #1; br = 0;
    repeat (4) begin @(posedge clk); #1; check("busy_no_read", ram_read, 0); end
    check("busy_stall", stall_if, 1);
    force_busy = 0;
    @(posedge clk); #1;
    check("busy_release_read", ram_read, 1);
    check("busy_ram_addr", ram_addr, 32'h2000);
    run(32'h2000, 2, 0, 100, 0);

    // PC wrap
    run(32'hFFFF_FFF8, 4, 1, 100, 0);

    // Reset during a refill
    cur_lat = 4; expect_abort = 1;
    model_fetch(32'h3000, 0);
    br = 1; br_addr = 32'h3000; @(posedge clk); #1; br = 0;
    wait_rd("rst");
    reset = 1; @(posedge clk); #1; reset = 0;
    check_reset_state("mid_reset");
    line_of.delete(); m_hit = 0; m_miss = 0;
    repeat (2) @(posedge clk);
    #1;
    expect_abort = 0; cur_lat = 3;
    run(32'h0, 2, 0, 100, 0);

    // Randomized runs with random busy and RAM latency
    rand_busy = 1; rand_lat = 1;
    for (int r = 0; r < 30; r++)
      run($urandom_range(0, 191) << 2, int'($urandom_range(0, 6)), 1,
          int'($urandom_range(30, 100)), 0);

    repeat (5) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
